// File: rtl/palette_bank.sv
// palette_bank: NUM_PAL runtime-writable 24-bit colour palettes behind a fixed 2-cycle index->RGB pipeline.
// Optional feature macro PALETTE_FADE_EN adds per-frame channel darkening in the output stage.
module palette_bank #(
   parameter int IDX_W   = 4,
   parameter int NUM_PAL = 2,
   parameter int PAL_W   = $clog2(NUM_PAL)
) (
   input  logic             Clk,
   input  logic             Reset_n,
   // Write handshake: an entry is written on the rising edge where wr_valid && wr_ready;
   // wr_ready is high for the whole RUN state and low while the clear sequence runs.
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [PAL_W-1:0] wr_pal,
   input  logic [IDX_W-1:0] wr_index,
   input  logic [23:0]      wr_rgb,
   input  logic             frame_start,
   input  logic [PAL_W-1:0] pal_sel,
   input  logic [2:0]       fade_level,
   input  logic             pix_valid,
   input  logic [IDX_W-1:0] pix_index,
   output logic             out_valid,
   output logic             out_transp,
   output logic [7:0]       Red,
   output logic [7:0]       Green,
   output logic [7:0]       Blue,
   output logic             busy,
   output logic             dbg_state
);
   localparam int                ADDR_W    = PAL_W + IDX_W;
   localparam int                DEPTH     = NUM_PAL << IDX_W;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
   localparam logic [PAL_W:0]    NUM_PAL_V = (PAL_W + 1)'(NUM_PAL);

   typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic [PAL_W-1:0]  active_pal_q, active_pal_d;

   logic              ram_we;
   logic [ADDR_W-1:0] ram_waddr;
   logic [23:0]       ram_wdata;
   logic [ADDR_W-1:0] rd_addr;
   logic [23:0]       rd_data_q;
   logic [23:0]       mem [DEPTH];

   logic              valid1_q, valid1_d;
   logic              transp1_q, transp1_d;
   logic              init1_q, init1_d;
   logic              out_valid_q, out_valid_d;
   logic              out_transp_q, out_transp_d;
   logic [23:0]       rgb_q, rgb_d;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q      <= S_INIT;
         clr_cnt_q    <= '0;
         active_pal_q <= '0;
      end else begin
         state_q      <= state_d;
         clr_cnt_q    <= clr_cnt_d;
         active_pal_q <= active_pal_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      if (state_q == S_INIT) begin
         if (clr_cnt_q == LAST_ADDR) begin
            state_d = S_RUN;
         end else begin
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
         end
      end
   end

   // The clear sequence owns the write port; writes to a nonexistent palette are dropped.
   always_comb begin
      busy      = (state_q == S_INIT);
      wr_ready  = (state_q == S_RUN);
      dbg_state = state_q;
      ram_we    = 1'b0;
      ram_waddr = clr_cnt_q;
      ram_wdata = '0;
      if (state_q == S_INIT) begin
         ram_we = 1'b1;
      end else if (wr_valid && ({1'b0, wr_pal} < NUM_PAL_V)) begin
         ram_we    = 1'b1;
         ram_waddr = {wr_pal, wr_index};
         ram_wdata = wr_rgb;
      end
   end

   always_comb begin
      active_pal_d = active_pal_q;
      if (frame_start) begin
         active_pal_d = ({1'b0, pal_sel} < NUM_PAL_V) ? pal_sel : '0;
      end
   end

   assign rd_addr = {active_pal_q, pix_index};

   // Read-first: a same-edge write is seen only by later reads.
   always_ff @(posedge Clk) begin
      if (ram_we) begin
         mem[ram_waddr] <= ram_wdata;
      end
      rd_data_q <= mem[rd_addr];
   end

`ifdef PALETTE_FADE_EN
   logic [2:0] active_fade_q, active_fade_d;
   logic [2:0] fade1_q, fade1_d;

   function automatic logic [7:0] fade_ch(input logic [7:0] c, input logic [2:0] f);
      logic [10:0] prod;
      prod = {3'b000, c} * (11'd8 - {8'd0, f});
      return prod[10:3];
   endfunction

   always_comb begin
      active_fade_d = frame_start ? fade_level : active_fade_q;
      fade1_d       = active_fade_q;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         active_fade_q <= '0;
         fade1_q       <= '0;
      end else begin
         active_fade_q <= active_fade_d;
         fade1_q       <= fade1_d;
      end
   end
`else
   logic unused_fade;
   assign unused_fade = ^fade_level;
`endif

   // Pixels sampled while the clear runs carry a flag that blanks their colour.
   always_comb begin
      valid1_d     = pix_valid;
      transp1_d    = (pix_index == '0);
      init1_d      = (state_q == S_INIT);
      out_valid_d  = valid1_q;
      out_transp_d = transp1_q;
      rgb_d        = '0;
      if (!init1_q) begin
`ifdef PALETTE_FADE_EN
         rgb_d = {fade_ch(rd_data_q[23:16], fade1_q),
                  fade_ch(rd_data_q[15:8], fade1_q),
                  fade_ch(rd_data_q[7:0], fade1_q)};
`else
         rgb_d = rd_data_q;
`endif
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         valid1_q     <= 1'b0;
         transp1_q    <= 1'b0;
         init1_q      <= 1'b1;
         out_valid_q  <= 1'b0;
         out_transp_q <= 1'b0;
         rgb_q        <= '0;
      end else begin
         valid1_q     <= valid1_d;
         transp1_q    <= transp1_d;
         init1_q      <= init1_d;
         out_valid_q  <= out_valid_d;
         out_transp_q <= out_transp_d;
         rgb_q        <= rgb_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_transp = out_transp_q;
   assign Red        = rgb_q[23:16];
   assign Green      = rgb_q[15:8];
   assign Blue       = rgb_q[7:0];

endmodule

// File: tb/tb_palette_bank.sv
// tb_palette_bank: directed vectors checked against a behavioural palette model every cycle,
// plus a 3-palette instance exercising out-of-range palette selects and writes.
`timescale 1ns/1ps
module tb_palette_bank;
   localparam int IDX_W  = 4;
   localparam int NUM_PAL = 2;
   localparam int PAL_W  = 1;
   localparam int ENTRIES = 2 ** IDX_W;
   localparam int DEPTH  = NUM_PAL * ENTRIES;
   localparam int DEPTH3 = 3 * ENTRIES;
`ifdef PALETTE_FADE_EN
   localparam bit FADE_ON = 1'b1;
`else
   localparam bit FADE_ON = 1'b0;
`endif

   logic             Clk = 1'b0;
   logic             Reset_n = 1'b0;
   logic             wr_valid, wr_ready;
   logic [PAL_W-1:0] wr_pal;
   logic [IDX_W-1:0] wr_index;
   logic [23:0]      wr_rgb;
   logic             frame_start;
   logic [PAL_W-1:0] pal_sel;
   logic [2:0]       fade_level;
   logic             pix_valid;
   logic [IDX_W-1:0] pix_index;
   logic             out_valid, out_transp, busy, dbg_state;
   logic [7:0]       Red, Green, Blue;

   logic             d3_wr_valid, d3_wr_ready;
   logic [1:0]       d3_wr_pal;
   logic [IDX_W-1:0] d3_wr_index;
   logic [23:0]      d3_wr_rgb;
   logic             d3_frame_start;
   logic [1:0]       d3_pal_sel;
   logic             d3_pix_valid;
   logic [IDX_W-1:0] d3_pix_index;
   logic             d3_out_valid, d3_out_transp, d3_busy, d3_dbg_state;
   logic [7:0]       d3_Red, d3_Green, d3_Blue;

   int n_checks = 0;
   int n_pass = 0;
   bit done = 1'b0;

   // ---------------- clock ----------------
   always #5 Clk = ~Clk;

   palette_bank #(.IDX_W(IDX_W), .NUM_PAL(NUM_PAL)) u_dut (
      .Clk(Clk), .Reset_n(Reset_n),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_pal(wr_pal), .wr_index(wr_index), .wr_rgb(wr_rgb),
      .frame_start(frame_start), .pal_sel(pal_sel), .fade_level(fade_level),
      .pix_valid(pix_valid), .pix_index(pix_index),
      .out_valid(out_valid), .out_transp(out_transp),
      .Red(Red), .Green(Green), .Blue(Blue), .busy(busy), .dbg_state(dbg_state)
   );

   palette_bank #(.IDX_W(IDX_W), .NUM_PAL(3)) u_dut3 (
      .Clk(Clk), .Reset_n(Reset_n),
      .wr_valid(d3_wr_valid), .wr_ready(d3_wr_ready), .wr_pal(d3_wr_pal), .wr_index(d3_wr_index),
      .wr_rgb(d3_wr_rgb), .frame_start(d3_frame_start), .pal_sel(d3_pal_sel), .fade_level(fade_level),
      .pix_valid(d3_pix_valid), .pix_index(d3_pix_index),
      .out_valid(d3_out_valid), .out_transp(d3_out_transp),
      .Red(d3_Red), .Green(d3_Green), .Blue(d3_Blue), .busy(d3_busy), .dbg_state(d3_dbg_state)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   logic [23:0] m_mem [NUM_PAL][ENTRIES];
   int          m_cnt;
   int          m_pal;
   int          m_fade;
   logic [25:0] exp_q[$];

   function automatic logic [23:0] m_colour(input logic [23:0] c, input int f);
      int r, g, b;
      r = (int'(c[23:16]) * (8 - f)) / 8;
      g = (int'(c[15:8]) * (8 - f)) / 8;
      b = (int'(c[7:0]) * (8 - f)) / 8;
      return {r[7:0], g[7:0], b[7:0]};
   endfunction

   initial begin
      m_cnt = 0;
      m_pal = 0;
      m_fade = 0;
      exp_q = {26'd0, 26'd0};
   end

   always @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         m_cnt = 0;
         m_pal = 0;
         m_fade = 0;
         exp_q = {26'd0, 26'd0};
      end else begin
         logic [23:0] c;
         c = (m_cnt < DEPTH) ? 24'h0 : m_colour(m_mem[m_pal][int'(pix_index)], m_fade);
         exp_q.push_back({pix_valid, pix_index == '0, c});
         void'(exp_q.pop_front());
         if (m_cnt < DEPTH) begin
            m_mem[m_cnt / ENTRIES][m_cnt % ENTRIES] = 24'h0;
            m_cnt++;
         end else if (wr_valid && int'(wr_pal) < NUM_PAL) begin
            m_mem[int'(wr_pal)][int'(wr_index)] = wr_rgb;
         end
         if (frame_start) begin
            m_pal = (int'(pal_sel) < NUM_PAL) ? int'(pal_sel) : 0;
            m_fade = FADE_ON ? int'(fade_level) : 0;
         end
      end
   end

   // ---------------- scoreboard compare ----------------
   initial begin
      forever begin
         @(negedge Clk);
         #1;
         if (!done) begin
            check("busy", busy, m_cnt < DEPTH);
            check("wr_ready", wr_ready, m_cnt >= DEPTH);
            check("out_valid", out_valid, exp_q[0][25]);
            if (exp_q[0][25] || !Reset_n) begin
               check("out_transp", out_transp, exp_q[0][24]);
               check("rgb", {Red, Green, Blue}, exp_q[0][23:0]);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: run did not complete by %0t", $time);
      $fatal(1, "watchdog expired");
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge Clk);
   endtask

   task automatic write(input int pal, input int idx, input logic [23:0] rgb);
      wr_valid = 1'b1;
      wr_pal = pal[PAL_W-1:0];
      wr_index = idx[IDX_W-1:0];
      wr_rgb = rgb;
      tick();
      wr_valid = 1'b0;
   endtask

   task automatic new_frame(input int pal, input int fade);
      frame_start = 1'b1;
      pal_sel = pal[PAL_W-1:0];
      fade_level = fade[2:0];
      tick();
      frame_start = 1'b0;
   endtask

   task automatic lookup_lit(input string name, input int idx, input logic [23:0] exp_rgb, input logic exp_t);
      pix_valid = 1'b1;
      pix_index = idx[IDX_W-1:0];
      tick();
      pix_valid = 1'b0;
      tick();
      check({name, "_valid"}, out_valid, 1);
      check({name, "_rgb"}, {Red, Green, Blue}, exp_rgb);
      check({name, "_transp"}, out_transp, exp_t);
   endtask

   task automatic measure_busy(input string name, input int exp_n, input int exp_n3);
      int n = 0;
      int n3 = 0;
      for (int i = 0; i < DEPTH3 + 10; i++) begin
         #1;
         if (busy) n++;
         if (d3_busy) n3++;
         tick();
      end
      check(name, n, exp_n);
      check({name, "_pal3"}, n3, exp_n3);
   endtask

   task automatic d3_write(input int pal, input int idx, input logic [23:0] rgb);
      d3_wr_valid = 1'b1;
      d3_wr_pal = pal[1:0];
      d3_wr_index = idx[IDX_W-1:0];
      d3_wr_rgb = rgb;
      tick();
      d3_wr_valid = 1'b0;
   endtask

   task automatic d3_lookup(input string name, input int pal, input int idx, input logic [23:0] exp_rgb);
      d3_frame_start = 1'b1;
      d3_pal_sel = pal[1:0];
      tick();
      d3_frame_start = 1'b0;
      d3_pix_valid = 1'b1;
      d3_pix_index = idx[IDX_W-1:0];
      tick();
      d3_pix_valid = 1'b0;
      tick();
      check({name, "_valid"}, d3_out_valid, 1);
      check({name, "_rgb"}, {d3_Red, d3_Green, d3_Blue}, exp_rgb);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      wr_valid = 0; wr_pal = '0; wr_index = '0; wr_rgb = '0;
      frame_start = 0; pal_sel = '0; fade_level = '0;
      pix_valid = 1; pix_index = '0;
      d3_wr_valid = 0; d3_wr_pal = '0; d3_wr_index = '0; d3_wr_rgb = '0;
      d3_frame_start = 0; d3_pal_sel = '0; d3_pix_valid = 0; d3_pix_index = '0;

      tick();
      tick();
      check("rst_busy", busy, 1);
      check("rst_wr_ready", wr_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_rgb", {Red, Green, Blue}, 24'h0);
      check("rst_transp", out_transp, 0);

      Reset_n = 1'b1;
      measure_busy("init_len", 32, 48);

      for (int i = 0; i < ENTRIES; i++) begin
         pix_index = i[IDX_W-1:0];
         tick();
      end
      new_frame(1, 0);
      for (int i = 0; i < ENTRIES; i++) begin
         pix_index = i[IDX_W-1:0];
         tick();
      end
      pix_valid = 1'b0;
      tick();
      tick();

      write(1, 3, 24'hF0A010);
      new_frame(1, 0);
      lookup_lit("pal1_idx3", 3, 24'hF0A010, 1'b0);
      lookup_lit("idx0_transp", 0, 24'h000000, 1'b1);

      write(1, 5, 24'h112233);
      wr_valid = 1'b1; wr_pal = 1'b1; wr_index = 4'd5; wr_rgb = 24'h445566;
      pix_valid = 1'b1; pix_index = 4'd5;
      tick();
      wr_valid = 1'b0;
      tick();
      pix_valid = 1'b0;
      check("raw_old", {Red, Green, Blue}, 24'h112233);
      tick();
      check("raw_new", {Red, Green, Blue}, 24'h445566);

      write(0, 7, 24'h0A0B0C);
      write(1, 7, 24'h102030);
      new_frame(0, 0);
      frame_start = 1'b1; pal_sel = 1'b1;
      pix_valid = 1'b1; pix_index = 4'd7;
      tick();
      frame_start = 1'b0;
      tick();
      pix_valid = 1'b0;
      check("fs_old_pal", {Red, Green, Blue}, 24'h0A0B0C);
      tick();
      check("fs_new_pal", {Red, Green, Blue}, 24'h102030);

      write(1, 9, 24'hF8F8F8);
      new_frame(1, 4);
      lookup_lit("fade4", 9, FADE_ON ? 24'h7C7C7C : 24'hF8F8F8, 1'b0);
      new_frame(1, 7);
      lookup_lit("fade7", 9, FADE_ON ? 24'h1F1F1F : 24'hF8F8F8, 1'b0);
      new_frame(0, 0);

      pix_valid = 1'b1;
      Reset_n = 1'b0;
      tick();
      Reset_n = 1'b1;
      repeat (10) tick();
      Reset_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_busy", busy, 1);
      check("midrst_rgb", {Red, Green, Blue}, 24'h0);
      tick();
      Reset_n = 1'b1;
      measure_busy("reinit_len", 32, 48);
      pix_valid = 1'b0;

      d3_write(0, 2, 24'hABCDEF);
      d3_write(2, 2, 24'h13579B);
      d3_write(3, 2, 24'h123456);
      d3_lookup("oor_sel", 3, 2, 24'hABCDEF);
      d3_lookup("pal2", 2, 2, 24'h13579B);

      tick();
      done = 1'b1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
